// File: rtl/mux_pkg.sv
// mux_pkg: shared constants/helpers for the N:1 round-robin buffered mux.
// Holds the lane-index width function, lane ceiling and data reset value.
package mux_pkg;

    localparam int NUM_LANES_MAX = 16;

    // replicated to DATA_W wherever a data register is cleared
    localparam bit DATA_RST = 1'b0;

    // lane index width, never narrower than one bit
    function automatic int lane_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_nto1_rr_buf_if.sv
// mux_nto1_rr_buf_if: lane-side and output-side ready/valid bundle.
// Ports: valid_in/data_in/ready_out per lane; valid_out/data_out/lane_out/ready_in.
// slave = mux side, master = source/sink side.
interface mux_nto1_rr_buf_if #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 8
);
    import mux_pkg::*;

    localparam int LANE_W = lane_w(NUM_LANES);

    logic [NUM_LANES-1:0]        valid_in;
    logic [NUM_LANES*DATA_W-1:0] data_in;
    logic [NUM_LANES-1:0]        ready_out;
    logic                        valid_out;
    logic [DATA_W-1:0]           data_out;
    logic [LANE_W-1:0]           lane_out;
    logic                        ready_in;

    modport slave (
        input  valid_in,
        input  data_in,
        output ready_out,
        output valid_out,
        output data_out,
        output lane_out,
        input  ready_in
    );

    modport master (
        output valid_in,
        output data_in,
        input  ready_out,
        input  valid_out,
        input  data_out,
        input  lane_out,
        output ready_in
    );

endinterface

// File: rtl/mux_lane_buf.sv
// mux_lane_buf: one-entry holding buffer for a single mux lane.
// Ports: clk, reset (async high), push, pop, din -> full, dout.
module mux_lane_buf
    import mux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic [DATA_W-1:0] dout
);

    logic              full_q;
    logic              full_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // push wins over pop: a simultaneous drain and refill stays full
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (push) begin
            full_d = 1'b1;
            data_d = din;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= {DATA_W{DATA_RST}};
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign dout = data_q;

endmodule

// File: rtl/mux_nto1_rr_buf.sv
// mux_nto1_rr_buf: NUM_LANES buffered ready/valid lanes merged into one
// registered output. Ports: clk, reset (async high), bus (slave modport).
// MUX_SKIP_EMPTY_EN: work-conserving round robin; else fixed TDM slots.
module mux_nto1_rr_buf
    import mux_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 8
) (
    input logic               clk,
    input logic               reset,
    mux_nto1_rr_buf_if.slave  bus
);

    localparam int LANE_W = lane_w(NUM_LANES);

    if (NUM_LANES < 2 || NUM_LANES > NUM_LANES_MAX) begin : g_bad_lanes
        $error("mux_nto1_rr_buf: NUM_LANES out of range");
    end

    if ($bits(bus.data_out) != DATA_W) begin : g_bad_width
        $error("mux_nto1_rr_buf: interface DATA_W mismatch");
    end

    logic [NUM_LANES-1:0] full;
    logic [NUM_LANES-1:0] drain;
    logic [NUM_LANES-1:0] push;
    logic [NUM_LANES-1:0] rdy;
    logic [DATA_W-1:0]    buf_data [NUM_LANES];

    logic [LANE_W-1:0]    ptr_q;
    logic [LANE_W-1:0]    ptr_d;
    logic                 valid_out_q;
    logic                 valid_out_d;
    logic [DATA_W-1:0]    data_out_q;
    logic [DATA_W-1:0]    data_out_d;
    logic [LANE_W-1:0]    lane_out_q;
    logic [LANE_W-1:0]    lane_out_d;

    logic                 slot_free;
    logic                 hit;
    logic [LANE_W-1:0]    win;

    // modular increment that never leaves 0..NUM_LANES-1
    function automatic logic [LANE_W-1:0] inc_lane(
        input logic [LANE_W-1:0] l
    );
        return (int'(l) == NUM_LANES - 1) ? '0 : l + 1'b1;
    endfunction

    // ready looks through a same-cycle drain, so it depends on ready_in
    assign rdy  = reset ? '0 : (~full | drain);
    assign push = bus.valid_in & rdy;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mux_lane_buf #(
            .DATA_W (DATA_W)
        ) u_buf (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .pop   (drain[i]),
            .din   (bus.data_in[i*DATA_W +: DATA_W]),
            .full  (full[i]),
            .dout  (buf_data[i])
        );
    end

    assign slot_free = !valid_out_q || bus.ready_in;

`ifdef MUX_SKIP_EMPTY_EN
    logic [LANE_W-1:0] cand;

    // first full lane at or after ptr, wrapping once around
    always_comb begin
        hit  = 1'b0;
        win  = ptr_q;
        cand = ptr_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!hit && full[cand]) begin
                hit = 1'b1;
                win = cand;
            end
            cand = inc_lane(cand);
        end
    end
`else
    // fixed slot: only the lane under ptr may be served
    always_comb begin
        hit = full[ptr_q];
        win = ptr_q;
    end
`endif

    always_comb begin
        ptr_d       = ptr_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        lane_out_d  = lane_out_q;
        drain       = '0;
        if (slot_free) begin
            valid_out_d = hit;
            if (hit) begin
                drain[win] = 1'b1;
                data_out_d = buf_data[win];
                lane_out_d = win;
            end
`ifdef MUX_SKIP_EMPTY_EN
            if (hit) begin
                ptr_d = inc_lane(win);
            end
`else
            ptr_d = inc_lane(ptr_q);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= {DATA_W{DATA_RST}};
            lane_out_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            lane_out_q  <= lane_out_d;
        end
    end

    assign bus.ready_out = rdy;
    assign bus.valid_out = valid_out_q;
    assign bus.data_out  = data_out_q;
    assign bus.lane_out  = lane_out_q;

endmodule

// File: tb/tb_mux_nto1_rr_buf.sv
// tb_mux_nto1_rr_buf: directed + scoreboard bench for mux_nto1_rr_buf.
// Instance a: 4 lanes x 8 bit; instance b: 3 lanes x 16 bit random traffic.
module tb_mux_nto1_rr_buf;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ra = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mux_nto1_rr_buf_if #(.NUM_LANES(4), .DATA_W(8))  if_a ();
    mux_nto1_rr_buf_if #(.NUM_LANES(3), .DATA_W(16)) if_b ();

    mux_nto1_rr_buf #(.NUM_LANES(4), .DATA_W(8)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (if_a)
    );

    mux_nto1_rr_buf #(.NUM_LANES(3), .DATA_W(16)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (if_b)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] lane;
        int         cyc;
    } exp_t;

    typedef struct {
        int          lane;
        logic [15:0] data;
    } expb_t;

    exp_t  qa[$];
    expb_t qb[$];
    exp_t  ea;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h cyc=%0d", name, act, want, cyc);
        end
    endtask

    task automatic expect_a(input logic [7:0] d, input int l, input int c);
        exp_t e;
        e.data = d;
        e.lane = 2'(l);
        e.cyc  = c;
        qa.push_back(e);
    endtask

    // scoreboard A: order, lane and exact cycle of every output transfer
    always @(negedge clk) begin
        if (!rst_a && if_a.valid_out && if_a.ready_in) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected data=%h lane=%0d cyc=%0d",
                         if_a.data_out, if_a.lane_out, cyc);
            end else begin
                ea = qa.pop_front();
                if (if_a.data_out !== ea.data || if_a.lane_out !== ea.lane ||
                    cyc != ea.cyc) begin
                    errors++;
                    $display("FAIL a_out got d=%h l=%0d c=%0d want d=%h l=%0d c=%0d",
                             if_a.data_out, if_a.lane_out, cyc,
                             ea.data, ea.lane, ea.cyc);
                end
            end
        end
    end

    // scoreboard B: per-lane arrival order, lane index range, ptr wrap
    int   prev_ptr_b = 0;
    logic wrapped = 1'b0;

    always @(negedge clk) begin
        if (!rst_b) begin
            if (int'(dut_b.ptr_q) == 0 && prev_ptr_b == 2) wrapped = 1'b1;
            prev_ptr_b = int'(dut_b.ptr_q);
            if (if_b.valid_out && if_b.ready_in) begin
                int hit_i;
                hit_i = -1;
                checks++;
                if (if_b.lane_out > 2'd2) begin
                    errors++;
                    $display("FAIL b_lane_range got=%0d want<3", if_b.lane_out);
                end else begin
                    for (int i = 0; i < qb.size(); i++) begin
                        if (hit_i < 0 && qb[i].lane == int'(if_b.lane_out))
                            hit_i = i;
                    end
                    if (hit_i < 0) begin
                        errors++;
                        $display("FAIL b_unexpected lane=%0d data=%h",
                                 if_b.lane_out, if_b.data_out);
                    end else begin
                        if (qb[hit_i].data !== if_b.data_out) begin
                            errors++;
                            $display("FAIL b_order lane=%0d got=%h want=%h",
                                     if_b.lane_out, if_b.data_out, qb[hit_i].data);
                        end
                        qb.delete(hit_i);
                    end
                end
            end
        end
    end

    task automatic wait_drain_a(input string name);
        int n = 0;
        while (qa.size() != 0 && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(name, qa.size(), 0);
        qa.delete();
    endtask

    task automatic reset_a();
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        if_a.valid_in = '0;
        if_a.ready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        ra = cyc;
    endtask

    task automatic run_a();
        logic [7:0] w [3];
        int         idx;
        logic       fire;

        // reset state
        @(negedge clk);
        chk("rst_valid", if_a.valid_out, 0);
        chk("rst_data", if_a.data_out, 0);
        chk("rst_lane", if_a.lane_out, 0);
        chk("rst_ready", if_a.ready_out, 0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        ra = cyc;

`ifndef MUX_SKIP_EMPTY_EN
        // TDM cadence: lane 2 only, served every 4th slot
        if_a.ready_in = 1'b1;
        if_a.valid_in = 4'b0100;
        if_a.data_in  = 32'h00A5_0000;
        for (int j = 0; j < 4; j++) expect_a(8'hA5, 2, ra + 3 + 4 * j);
        @(posedge clk);
        @(negedge clk);
        chk("tdm_rdy_full", if_a.ready_out, 4'b1011);
        @(posedge clk);
        @(negedge clk);
        chk("tdm_rdy_drain", if_a.ready_out, 4'b1111);
        repeat (10) @(posedge clk);
        #1;
        if_a.valid_in = '0;
        wait_drain_a("tdm_drain");
`else
        // skip-empty: lanes 1 and 3 alternate with no bubbles
        if_a.ready_in = 1'b1;
        if_a.valid_in = 4'b1010;
        if_a.data_in  = 32'h3300_1100;
        for (int k = 0; k < 9; k++) begin
            if (k % 2 == 0) expect_a(8'h11, 1, ra + 2 + k);
            else            expect_a(8'h33, 3, ra + 2 + k);
        end
        @(posedge clk);
        @(negedge clk);
        chk("skip_rdy", if_a.ready_out, 4'b0111);
        repeat (7) @(posedge clk);
        #1;
        if_a.valid_in = '0;
        wait_drain_a("skip_drain");
`endif

        // reset mid-stream with all buffers full and output loaded
        if_a.ready_in = 1'b0;
        if_a.valid_in = 4'b1111;
        if_a.data_in  = 32'h5352_5150;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_valid", if_a.valid_out, 1);
        rst_a = 1'b1;
        #1;
        chk("mid_rst_valid", if_a.valid_out, 0);
        chk("mid_rst_data", if_a.data_out, 0);
        chk("mid_rst_lane", if_a.lane_out, 0);
        chk("mid_rst_ready", if_a.ready_out, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_rst_ready", if_a.ready_out, 0);
        if_a.valid_in = '0;
        rst_a = 1'b0;
        ra = cyc;
        #1;
        chk("post_rst_ready", if_a.ready_out, 4'b1111);

        // backpressure: fill all lanes, stall 5 cycles, then release
        if_a.valid_in = 4'b1111;
        if_a.data_in  = 32'h1312_1110;
`ifndef MUX_SKIP_EMPTY_EN
        expect_a(8'h11, 1, ra + 7);
        expect_a(8'h12, 2, ra + 8);
        expect_a(8'h13, 3, ra + 9);
        expect_a(8'h10, 0, ra + 10);
        expect_a(8'h21, 1, ra + 11);
`else
        expect_a(8'h10, 0, ra + 7);
        expect_a(8'h11, 1, ra + 8);
        expect_a(8'h12, 2, ra + 9);
        expect_a(8'h13, 3, ra + 10);
        expect_a(8'h20, 0, ra + 11);
`endif
        @(posedge clk);
        @(negedge clk);
`ifndef MUX_SKIP_EMPTY_EN
        chk("bp_rdy_first", if_a.ready_out, 4'b0010);
`else
        chk("bp_rdy_first", if_a.ready_out, 4'b0001);
`endif
        if_a.data_in = 32'h2322_2120;
        @(posedge clk);
        #1;
        if_a.valid_in = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", if_a.valid_out, 1);
            chk("bp_ready", if_a.ready_out, 0);
`ifndef MUX_SKIP_EMPTY_EN
            chk("bp_data", if_a.data_out, 8'h11);
            chk("bp_lane", if_a.lane_out, 1);
            chk("bp_ptr", dut_a.ptr_q, 2);
`else
            chk("bp_data", if_a.data_out, 8'h10);
            chk("bp_lane", if_a.lane_out, 0);
            chk("bp_ptr", dut_a.ptr_q, 1);
`endif
        end
        @(posedge clk);
        #1;
        if_a.ready_in = 1'b1;
        wait_drain_a("bp_drain");

        // lane 0 streams 01,02,03 honouring its ready handshake
        reset_a();
        if_a.ready_in = 1'b1;
        w[0] = 8'h01;
        w[1] = 8'h02;
        w[2] = 8'h03;
`ifndef MUX_SKIP_EMPTY_EN
        expect_a(8'h01, 0, ra + 5);
        expect_a(8'h02, 0, ra + 9);
        expect_a(8'h03, 0, ra + 13);
`else
        expect_a(8'h01, 0, ra + 2);
        expect_a(8'h02, 0, ra + 3);
        expect_a(8'h03, 0, ra + 4);
`endif
        idx = 0;
        for (int c = 0; c < 16 && idx < 3; c++) begin
            if_a.valid_in = 4'b0001;
            if_a.data_in  = {24'h0, w[idx]};
            @(negedge clk);
            fire = if_a.ready_out[0];
`ifndef MUX_SKIP_EMPTY_EN
            if (cyc == ra + 2) chk("dp_rdy_full", fire, 0);
            if (cyc == ra + 4) chk("dp_rdy_drain", fire, 1);
`else
            if (cyc == ra + 1) chk("dp_rdy_b2b1", fire, 1);
            if (cyc == ra + 2) chk("dp_rdy_b2b2", fire, 1);
`endif
            @(posedge clk);
            #1;
            if (fire) idx++;
        end
        if_a.valid_in = '0;
        chk("dp_all_sent", idx, 3);
        wait_drain_a("dp_drain");
    endtask

    task automatic run_b();
        logic [2:0]  vb;
        logic [2:0]  fb;
        logic [15:0] db [3];
        expb_t       e;
        int          n;

        vb = '0;
        fb = '0;
        for (int i = 0; i < 3; i++) db[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!vb[i] || fb[i]) begin
                    vb[i] = (c < 500) ? 1'($urandom_range(0, 1)) : 1'b0;
                    db[i] = 16'($urandom_range(0, 65535));
                end
            end
            if_b.valid_in = vb;
            if_b.data_in  = {db[2], db[1], db[0]};
            if_b.ready_in = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                fb[i] = vb[i] && if_b.ready_out[i];
                if (fb[i]) begin
                    e.lane = i;
                    e.data = db[i];
                    qb.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        if_b.valid_in = '0;
        if_b.ready_in = 1'b1;
        n = 0;
        while (qb.size() != 0 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("b_drain", qb.size(), 0);
        chk("b_ptr_wrap", wrapped, 1);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.valid_in = '0;
        if_a.data_in  = '0;
        if_a.ready_in = 1'b0;
        if_b.valid_in = '0;
        if_b.data_in  = '0;
        if_b.ready_in = 1'b0;
        fork
            run_a();
            run_b();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
